// File: rtl/vga_fb_arbiter.sv
// Shares a single-port, double-buffered 160x120x3 framebuffer between VGA scan-out
// and a pixel writer, and flips the displayed bank at the end of active video.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_W     = H_ACTIVE >> 2,
  parameter int FB_SIZE  = 19200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic        disp_en,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [2:0]  wr_data,
  output logic        wr_ack,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        front_sel,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata,
  output logic [2:0]  pix_rgb,
  output logic        pix_valid
);

  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [15:0] BANK_SZ = 16'(FB_SIZE);
  localparam int          PIPE    = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISP,
    SLOT_WR
  } slot_t;

  typedef enum logic {
    SW_IDLE,
    SW_PEND
  } swap_state_t;

  logic        in_active;
  logic        grp_start;
  logic        at_boundary;
  slot_t       slot;

  logic [15:0] fb_y;
  logic [15:0] fb_x;
  logic [15:0] row_off;
  logic [15:0] disp_addr;
  logic [15:0] wr_base;
  logic [15:0] wr_full_addr;
  logic        wr_in_range;

  logic [15:0] mem_addr_next;
  logic [2:0]  mem_wdata_next;
  logic        mem_we_next;
  logic        wr_ack_next;

  swap_state_t swap_reg;
  swap_state_t swap_next;
  logic        swap_fire;

  logic [PIPE-1:0] act_sr;
  logic [PIPE-2:0] grp_sr;
  logic [PIPE-2:0] fetch_sr;
  logic [2:0]      pix_reg;

  always_comb begin
    in_active   = (hcnt < H_ACT) && (vcnt < V_ACT);
    grp_start   = in_active && (hcnt[1:0] == 2'b00);
    at_boundary = (vcnt == V_ACT) && (hcnt == 10'd0);
  end

  // One framebuffer pixel covers a 4x4 block of screen pixels.
  assign fb_y = {8'd0, vcnt[9:2]};
  assign fb_x = {8'd0, hcnt[9:2]};

  generate
    if (FB_W == 160) begin : g_row_shift
      assign row_off = (fb_y << 7) + (fb_y << 5);
    end else begin : g_row_mul
      assign row_off = 16'(fb_y * 16'(FB_W));
    end
  endgenerate

  assign disp_addr    = (front_sel ? BANK_SZ : 16'd0) + row_off + fb_x;
  assign wr_base      = front_sel ? 16'd0 : BANK_SZ;
  assign wr_full_addr = wr_base + {1'b0, wr_addr};
  assign wr_in_range  = ({1'b0, wr_addr} < BANK_SZ);

  // Scan-out owns the first cycle of every 4-pixel group; masking on wr_ack
  // keeps an already-granted request from being served twice.
  always_comb begin
    slot = SLOT_IDLE;
    if (grp_start && disp_en) begin
      slot = SLOT_DISP;
    end else if (wr_req && !wr_ack) begin
      slot = SLOT_WR;
    end
  end

  always_comb begin
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_we_next    = 1'b0;
    wr_ack_next    = 1'b0;
    case (slot)
      SLOT_DISP: begin
        mem_addr_next = disp_addr;
      end
      SLOT_WR: begin
        mem_addr_next  = wr_full_addr;
        mem_wdata_next = wr_data;
        mem_we_next    = wr_in_range;
        wr_ack_next    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= 16'd0;
      mem_wdata <= 3'd0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_we    <= mem_we_next;
      wr_ack    <= wr_ack_next;
    end
  end

  // A request on the boundary cycle itself is honoured immediately.
  always_comb begin
    swap_next = swap_reg;
    swap_fire = 1'b0;
    case (swap_reg)
      SW_IDLE: begin
        if (at_boundary && swap_req) begin
          swap_fire = 1'b1;
        end else if (swap_req) begin
          swap_next = SW_PEND;
        end
      end
      SW_PEND: begin
        if (at_boundary) begin
          swap_fire = 1'b1;
          swap_next = SW_IDLE;
        end
      end
      default: begin
        swap_next = SW_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_reg  <= SW_IDLE;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_reg  <= swap_next;
      swap_done <= swap_fire;
      if (swap_fire) begin
        front_sel <= ~front_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_sr   <= '0;
      grp_sr   <= '0;
      fetch_sr <= '0;
    end else begin
      act_sr   <= {act_sr[PIPE-2:0], in_active};
      grp_sr   <= {grp_sr[PIPE-3:0], grp_start};
      fetch_sr <= {fetch_sr[PIPE-3:0], (slot == SLOT_DISP)};
    end
  end

  // Reload at every group start so a group without a fetch shows black
  // instead of repeating the previous group's colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_reg <= 3'd0;
    end else if (grp_sr[PIPE-2]) begin
      pix_reg <= fetch_sr[PIPE-2] ? mem_rdata : 3'd0;
    end
  end

  assign pix_valid = act_sr[PIPE-1];
  assign pix_rgb   = act_sr[PIPE-1] ? pix_reg : 3'd0;

endmodule
